// File: rtl/sp_ram_pipe_model.sv
// Single-port RAM model with column write enables, optional zero-clear after reset,
// selectable read-during-write return and 0..2 extra output register stages.
// Latency: 1+OUT_REGS cycles from access to DO/DO_VALID; no backpressure, BUSY locks out accesses while clearing.
//
// Ports:
//   CLK      rising-edge clock
//   RST      synchronous active-high reset (pipeline + clear sequencer; RAM contents untouched)
//   CE       access enable; RDWEN 1 = write, 0 = read
//   A        word address; DI write data; BW per-column write enable
//   DO       read / write-return data, holds the last returned word
//   DO_VALID one-cycle pulse marking a fresh word on DO
//   BUSY     clear sequence running; all accesses ignored
module sp_ram_pipe_model #(
    parameter int ADDR_WIDTH     = 4,
    parameter int COL_WIDTH      = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int OUT_REGS       = 0,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int NUM_COL       = DATA_WIDTH / COL_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CE,
    input  logic                  RDWEN,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] DI,
    input  logic [NUM_COL-1:0]    BW,
    output logic [DATA_WIDTH-1:0] DO,
    output logic                  DO_VALID,
    output logic                  BUSY
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Parameter sanity checks, evaluated at elaboration.
    if (DATA_WIDTH % COL_WIDTH != 0) begin : g_bad_col
        $fatal(1, "sp_ram_pipe_model: DATA_WIDTH must be a multiple of COL_WIDTH");
    end
    if (OUT_REGS > 2) begin : g_bad_out_regs
        $fatal(1, "sp_ram_pipe_model: OUT_REGS must be 0..2");
    end
    if (RDW_MODE > 2) begin : g_bad_rdw
        $fatal(1, "sp_ram_pipe_model: RDW_MODE must be 0..2");
    end

    typedef enum logic {
        ST_READY = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [ADDR_WIDTH-1:0]   ptr_nxt;
    logic                    clr_we;
    logic                    busy;
    logic                    acc;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   wr_word;
    logic [DATA_WIDTH-1:0]   ret_word;
    logic                    ret_vld;

    logic [DATA_WIDTH-1:0]   pipe_dat [OUT_REGS+1];
    logic [OUT_REGS:0]       pipe_vld;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        clr_we    = 1'b0;
        if (state == ST_CLEAR) begin
            clr_we  = 1'b1;
            ptr_nxt = ptr + 1'b1;
            // Last word cleared this cycle: BUSY drops at this edge.
            if (ptr == '1) begin
                state_nxt = ST_READY;
            end
        end
    end

    // With clearing disabled BUSY is tied low regardless of the state register.
    assign busy = (CLEAR_ON_RESET != 0) && (state == ST_CLEAR);
    assign BUSY = busy;
    assign acc  = CE && !busy && !RST;

    // ------------------------------------------------------------------
    // Array access
    // ------------------------------------------------------------------
    assign rd_word = mem[A];

    // Post-write word: new data in enabled columns, old data elsewhere.
    always_comb begin
        wr_word = rd_word;
        for (int i = 0; i < NUM_COL; i++) begin
            if (BW[i]) begin
                wr_word[i*COL_WIDTH +: COL_WIDTH] = DI[i*COL_WIDTH +: COL_WIDTH];
            end
        end
    end

    always_comb begin
        ret_vld  = 1'b0;
        ret_word = rd_word;
        if (acc) begin
            if (!RDWEN) begin
                ret_vld = 1'b1;
            end else if (RDW_MODE == 1) begin
                ret_vld = 1'b1;
            end else if (RDW_MODE == 2) begin
                ret_vld  = 1'b1;
                ret_word = wr_word;
            end
        end
    end

    // No reset on the array itself; RST only restarts the clear sequencer.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (clr_we) begin
                mem[ptr] <= '0;
            end else if (acc && RDWEN) begin
                for (int i = 0; i < NUM_COL; i++) begin
                    if (BW[i]) begin
                        mem[A][i*COL_WIDTH +: COL_WIDTH] <= DI[i*COL_WIDTH +: COL_WIDTH];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output pipeline: valids shift every cycle, data stages load only on
    // an incoming valid so DO holds the most recent returned word.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            pipe_vld <= '0;
            for (int s = 0; s <= OUT_REGS; s++) begin
                pipe_dat[s] <= '0;
            end
        end else begin
            pipe_vld[0] <= ret_vld;
            if (ret_vld) begin
                pipe_dat[0] <= ret_word;
            end
            for (int s = 1; s <= OUT_REGS; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                if (pipe_vld[s-1]) begin
                    pipe_dat[s] <= pipe_dat[s-1];
                end
            end
        end
    end

    assign DO       = pipe_dat[OUT_REGS];
    assign DO_VALID = pipe_vld[OUT_REGS];

endmodule
